// File: rtl/fb_scan_arbiter.sv
// Frame-buffer port arbiter: VGA scan-out reads have priority; cell writes and a hardware clear fill the gaps.
// Optional FB_RANGE_CHECK_EN: out-of-range writes are handshaken but dropped, and a sticky wr_err is raised.
module fb_scan_arbiter #(
    parameter int H_START   = 145,
    parameter int V_START   = 32,
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int CELL_LOG2 = 3,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 13,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              wr_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    localparam int          CELL    = 1 << CELL_LOG2;
    localparam int unsigned CELLS   = COLS * ROWS;
    localparam logic [10:0] SLOT0   = 11'(H_START - 2);
    localparam logic [9:0]  V_FIRST = 10'(V_START);
    localparam logic [9:0]  V_LAST  = 10'(V_START + ROWS * CELL - 1);
    localparam logic [9:0]  H_LAST  = 10'(H_START + COLS * CELL - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic [10:0]       hc_off, slot_k;
    logic [9:0]        v_off, row;
    logic              active_row, slot;
    logic [ADDR_W-1:0] slot_addr;
    logic              rd_pend, rd_first;
    logic              wr_fire, wr_oob;

    // Slots sit two pixels ahead of each cell so the registered read lands on the cell's first pixel.
    assign hc_off     = {1'b0, hc} - SLOT0;
    assign slot_k     = hc_off >> CELL_LOG2;
    assign active_row = (vc >= V_FIRST) && (vc <= V_LAST);
    assign slot       = active_row && ({1'b0, hc} >= SLOT0) &&
                        (hc_off[CELL_LOG2-1:0] == '0) && (slot_k < 11'(COLS));
    assign v_off      = vc - V_FIRST;
    assign row        = v_off >> CELL_LOG2;
    assign slot_addr  = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(slot_k);

    assign clr_last   = (clr_cnt == ADDR_W'(CELLS - 1));
    assign clear_busy = (state == ST_CLEAR);
    assign wr_ready   = !rst && (state == ST_IDLE) && !slot && !clear_req;
    assign wr_fire    = wr_valid && wr_ready;

`ifdef FB_RANGE_CHECK_EN
    assign wr_oob = (32'(wr_addr) >= CELLS);

    always_ff @(posedge clk) begin
        if (rst)
            wr_err <= 1'b0;
        else if (wr_fire && wr_oob)
            wr_err <= 1'b1;
    end
`else
    assign wr_oob = 1'b0;
    assign wr_err = 1'b0;
`endif

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (slot) begin
                ram_en   = 1'b1;
                ram_addr = slot_addr;
            end else if (state == ST_CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = CLEAR_VAL;
            end else if (wr_fire && !wr_oob) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = wr_addr;
                ram_wdata = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            clr_cnt   <= '0;
            rd_pend   <= 1'b0;
            rd_first  <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else begin
            rd_pend  <= slot;
            rd_first <= slot && (slot_k == '0);
            if (rd_pend)
                pix_data <= ram_rdata;
            if (rd_pend && rd_first)
                pix_valid <= 1'b1;
            else if (hc == H_LAST)
                pix_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    if (!slot) begin
                        if (clr_last) begin
                            state   <= ST_IDLE;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Scoreboard bench for fb_scan_arbiter: stimulus queues expected RAM accesses and pixel words, a monitor pops them.
module tb_fb_scan_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hc, vc;
    logic        wr_valid, wr_ready;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        clear_req, clear_busy, wr_err;
    logic        ram_en, ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;

    fb_scan_arbiter dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .wr_err(wr_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle read latency; preload fills mem[a] = a[7:0].
    logic       preload;
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'(i);
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [21:0] ram_q [$];
    logic [7:0]  pix_q [$];
    logic [7:0]  exp_mem [0:4799];

    function automatic void push_ram(input bit we, input int addr, input int data);
        ram_q.push_back({we, 13'(addr), 8'(data)});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RAM access and every valid pixel is matched against the head of its queue.
    logic [21:0] e_ram;
    logic [7:0]  e_pix;
    initial forever begin
        @(negedge clk);
        if (ram_en) begin
            vec_cnt++;
            if (ram_q.size() == 0) begin
                err_cnt++;
                $display("FAIL ram_access: got unexpected we=%0d addr=%0d data=%0h, expected none",
                         ram_we, ram_addr, ram_wdata);
            end else begin
                e_ram = ram_q.pop_front();
                if (ram_we !== e_ram[21] || ram_addr !== e_ram[20:8] ||
                    (e_ram[21] && ram_wdata !== e_ram[7:0])) begin
                    err_cnt++;
                    $display("FAIL ram_access: got we=%0d addr=%0d data=%0h, expected we=%0d addr=%0d data=%0h",
                             ram_we, ram_addr, ram_wdata, e_ram[21], e_ram[20:8], e_ram[7:0]);
                end
            end
        end
        if (pix_valid) begin
            vec_cnt++;
            if (pix_q.size() == 0) begin
                err_cnt++;
                $display("FAIL pix: got unexpected pix_valid hc=%0d data=%0h, expected none", hc, pix_data);
            end else begin
                e_pix = pix_q.pop_front();
                if (pix_data !== e_pix) begin
                    err_cnt++;
                    $display("FAIL pix: hc=%0d got %0h, expected %0h", hc, pix_data, e_pix);
                end
            end
        end
    end

    // Full scan line on vc=v; slots at 143+8k read row*80+k, pixels 145..784 show the read words.
    task automatic sweep_row(input int v);
        int row;
        row = (v - 32) >> 3;
        for (int h = 0; h < 800; h++) begin
            step();
            hc = 10'(h);
            vc = 10'(v);
            if (h >= 143 && h <= 775 && (h - 143) % 8 == 0) push_ram(1'b0, row * 80 + (h - 143) / 8, 0);
            if (h >= 145 && h <= 784) pix_q.push_back(exp_mem[row * 80 + (h - 145) / 8]);
        end
        step();
        hc = '0;
        vc = '0;
    endtask

    initial begin
        int busy_cnt, bad, diff;
        rst = 1'b1; hc = '0; vc = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clear_req = 1'b0; preload = 1'b1;
        for (int i = 0; i < 4800; i++) exp_mem[i] = 8'(i);

        // Reset state, with hc/vc parked on a slot to show RAM outputs are gated.
        step(); step();
        preload = 1'b0; hc = 10'd143; vc = 10'd32;
        #1;
        chk("rst ram_en", ram_en, 0);
        chk("rst wr_ready", wr_ready, 0);
        chk("rst pix_data", pix_data, 0);
        chk("rst pix_valid", pix_valid, 0);
        chk("rst clear_busy", clear_busy, 0);
        chk("rst wr_err", wr_err, 0);
        step(); rst = 1'b0; hc = '0; vc = '0;
        #1;
        chk("idle wr_ready", wr_ready, 1);

        // Scan-out of row 0 over preloaded RAM.
        sweep_row(32);

        // Writer collides with the k=1 slot, then lands one cycle later.
        step(); hc = 10'd151; vc = 10'd32; wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 8'hA5;
        push_ram(1'b0, 1, 0);
        #1; chk("wr_ready at slot", wr_ready, 0);
        step(); hc = 10'd152;
        push_ram(1'b1, 5, 8'hA5);
        #1; chk("wr_ready after slot", wr_ready, 1);
        step(); hc = 10'd153; wr_valid = 1'b0;
        step(); hc = '0; vc = '0;
        exp_mem[5] = 8'hA5;
        sweep_row(32);

        // Partial clear interrupted by reset after 100 writes.
        step(); preload = 1'b1;
        step(); preload = 1'b0; clear_req = 1'b1;
        for (int i = 0; i < 100; i++) push_ram(1'b1, i, 0);
        for (int i = 0; i < 100; i++) begin
            step(); clear_req = 1'b0;
            #1; chk("partial clear_busy", clear_busy, 1);
        end
        step(); rst = 1'b1;
        #1; chk("rst mid-clear ram_en", ram_en, 0);
        step(); rst = 1'b0;
        #1;
        chk("clear_busy after rst", clear_busy, 0);
        chk("wr_ready after rst", wr_ready, 1);
        for (int i = 0; i < 4800; i++) exp_mem[i] = (i < 100) ? 8'h00 : 8'(i);
        diff = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== exp_mem[i]) diff++;
        chk("partial clear ram diffs", diff, 0);
        sweep_row(40);

        // clear_req with wr_valid: clear wins, then a full 4800-write clear from address 0.
        step(); clear_req = 1'b1; wr_valid = 1'b1; wr_addr = 13'd7; wr_data = 8'h33;
        for (int i = 0; i < 4800; i++) push_ram(1'b1, i, 0);
        #1; chk("wr_ready with clear_req", wr_ready, 0);
        busy_cnt = 0; bad = 0;
        for (int n = 0; n < 4900; n++) begin
            step(); clear_req = 1'b0; wr_valid = 1'b0;
            #1;
            if (clear_busy) begin
                busy_cnt++;
                if (wr_ready) bad++;
            end else if (n > 0) begin
                break;
            end
        end
        chk("clear_busy cycles", busy_cnt, 4800);
        chk("wr_ready during clear", bad, 0);
        diff = 0;
        for (int i = 0; i < 4800; i++) if (mem[i] !== 8'h00) diff++;
        chk("full clear nonzero words", diff, 0);
        for (int i = 0; i < 4800; i++) exp_mem[i] = 8'h00;
        sweep_row(32 + 59 * 8);

        // Out-of-range write at address 4800.
        step(); wr_valid = 1'b1; wr_addr = 13'd4800; wr_data = 8'h5A;
`ifndef FB_RANGE_CHECK_EN
        push_ram(1'b1, 4800, 8'h5A);
`endif
        #1; chk("oob wr_ready", wr_ready, 1);
        step(); wr_valid = 1'b0;
        #1;
`ifdef FB_RANGE_CHECK_EN
        chk("wr_err set", wr_err, 1);
        step(); step(); step();
        chk("wr_err sticky", wr_err, 1);
        chk("oob ram untouched", mem[4800], 8'(4800));
`else
        chk("wr_err tied low", wr_err, 0);
        chk("oob ram written", mem[4800], 8'h5A);
`endif
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        #1; chk("wr_err after rst", wr_err, 0);

        step(); step();
        chk("ram_q drained", ram_q.size(), 0);
        chk("pix_q drained", pix_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
